// File: rtl/sysahb_arbiter_if.sv
// Bundle of every bus-side signal of the two-master system AHB arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface sysahb_arbiter_if;
  logic        m0_hbusreq;
  logic        m0_hlock;
  logic [31:0] m0_haddr;
  logic [1:0]  m0_htrans;
  logic        m0_hwrite;
  logic [2:0]  m0_hsize;
  logic [2:0]  m0_hburst;
  logic [3:0]  m0_hprot;
  logic [31:0] m0_hwdata;
  logic        m0_hgrant;

  logic        m1_hbusreq;
  logic        m1_hlock;
  logic [31:0] m1_haddr;
  logic [1:0]  m1_htrans;
  logic        m1_hwrite;
  logic [2:0]  m1_hsize;
  logic [2:0]  m1_hburst;
  logic [3:0]  m1_hprot;
  logic [31:0] m1_hwdata;
  logic        m1_hgrant;

  logic        mst_hready;
  logic        mst_hresp;
  logic [31:0] mst_hrdata;

  logic [31:0] sysahb_haddr;
  logic [1:0]  sysahb_htrans;
  logic        sysahb_hwrite;
  logic [2:0]  sysahb_hsize;
  logic [2:0]  sysahb_hburst;
  logic [3:0]  sysahb_hprot;
  logic [31:0] sysahb_hwdata;
  logic        sysahb_hmastlock;
  logic        sysahb_hready;
  logic        sysahb_hresp;
  logic [31:0] sysahb_hrdata;
  logic        hmaster;

  modport slave (
    input  m0_hbusreq, m0_hlock, m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hwdata,
    input  m1_hbusreq, m1_hlock, m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hwdata,
    output m0_hgrant, m1_hgrant,
    output mst_hready, mst_hresp, mst_hrdata,
    output sysahb_haddr, sysahb_htrans, sysahb_hwrite, sysahb_hsize, sysahb_hburst, sysahb_hprot,
    output sysahb_hwdata, sysahb_hmastlock, hmaster,
    input  sysahb_hready, sysahb_hresp, sysahb_hrdata
  );

  modport master (
    output m0_hbusreq, m0_hlock, m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hwdata,
    output m1_hbusreq, m1_hlock, m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hwdata,
    input  m0_hgrant, m1_hgrant,
    input  mst_hready, mst_hresp, mst_hrdata,
    input  sysahb_haddr, sysahb_htrans, sysahb_hwrite, sysahb_hsize, sysahb_hburst, sysahb_hprot,
    input  sysahb_hwdata, sysahb_hmastlock, hmaster,
    output sysahb_hready, sysahb_hresp, sysahb_hrdata
  );
endinterface

// File: rtl/sysahb_arbiter.sv
// Two-master AHB-Lite arbiter/mux: AHB2 request/grant, round-robin with a hold quantum,
// bursts (SEQ beats) and locked sequences are never split.
module sysahb_arbiter #(
  parameter bit          PARK    = 1'b0,
  parameter int unsigned QUANTUM = 16
) (
  input logic              sys_clk,
  input logic              sys_rst,
  sysahb_arbiter_if.slave  bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam logic [7:0] QUANTUM_L   = 8'(QUANTUM);

  logic       grant;
  logic       hmaster;
  logic       hmaster_d;
  logic [7:0] hold_cnt;

  logic [1:0] own_trans;
  logic       own_lock;
  logic       rearb;
  logic       grant_nxt;

  assign own_trans = hmaster ? bus.m1_htrans : bus.m0_htrans;
  assign own_lock  = hmaster ? bus.m1_hlock  : bus.m0_hlock;

  // A SEQ beat or an asserted lock pins the current owner; grant only moves between transfers.
  assign rearb = bus.sysahb_hready && (own_trans != HTRANS_SEQ) && !own_lock;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_nxt = grant;
    if (rearb) begin
      unique case ({bus.m1_hbusreq, bus.m0_hbusreq})
        2'b01:   grant_nxt = 1'b0;
        2'b10:   grant_nxt = 1'b1;
        2'b11:   grant_nxt = (hold_cnt >= QUANTUM_L) ? ~hmaster : hmaster;
        default: grant_nxt = PARK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant     <= PARK;
      hmaster   <= PARK;
      hmaster_d <= PARK;
      hold_cnt  <= 8'd0;
    end else if (bus.sysahb_hready) begin
      grant     <= grant_nxt;
      hmaster   <= grant;
      hmaster_d <= hmaster;
      if (grant != hmaster)
        hold_cnt <= 8'd0;
      else if (own_trans[1] && (hold_cnt != 8'hFF))
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign bus.m0_hgrant = ~grant;
  assign bus.m1_hgrant = grant;
  assign bus.hmaster   = hmaster;

  assign bus.sysahb_haddr     = hmaster ? bus.m1_haddr  : bus.m0_haddr;
  assign bus.sysahb_hwrite    = hmaster ? bus.m1_hwrite : bus.m0_hwrite;
  assign bus.sysahb_hsize     = hmaster ? bus.m1_hsize  : bus.m0_hsize;
  assign bus.sysahb_hburst    = hmaster ? bus.m1_hburst : bus.m0_hburst;
  assign bus.sysahb_hprot     = hmaster ? bus.m1_hprot  : bus.m0_hprot;
  assign bus.sysahb_htrans    = sys_rst ? HTRANS_IDLE : own_trans;
  assign bus.sysahb_hmastlock = sys_rst ? 1'b0 : own_lock;

  // Write data belongs to the data-phase owner, which lags the address owner by one ready cycle.
  assign bus.sysahb_hwdata = hmaster_d ? bus.m1_hwdata : bus.m0_hwdata;

  assign bus.mst_hready = bus.sysahb_hready;
  assign bus.mst_hresp  = bus.sysahb_hresp;
  assign bus.mst_hrdata = bus.sysahb_hrdata;

endmodule

// File: tb/tb_sysahb_arbiter.sv
// Randomized bench for sysahb_arbiter: a cycle-level reference model of the arbitration
// rules predicts grants, ownership and every muxed output each cycle.
module tb_sysahb_arbiter;

  localparam bit TB_PARK    = 1'b0;
  localparam int TB_QUANTUM = 4;

  typedef struct {
    int req0;
    int req1;
    int seq;
    int lock;
    int ready;
    int rst;
  } phase_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_grant, m_owner, m_data_owner, m_beats;
  int   lock_run [2];

  sysahb_arbiter_if bus ();

  sysahb_arbiter #(.PARK(TB_PARK), .QUANTUM(TB_QUANTUM)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant      = int'(TB_PARK);
    m_owner      = int'(TB_PARK);
    m_data_owner = int'(TB_PARK);
    m_beats      = 0;
  endtask

  // Called at posedge+1 with inputs already applied: checks outputs, advances model, crosses one edge.
  task automatic step();
    logic [1:0]  tr [2];
    logic        lk [2];
    logic        rq [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [10:0] ct [2];
    int o, n, nxt;
    #1;
    tr[0] = bus.m0_htrans;  tr[1] = bus.m1_htrans;
    lk[0] = bus.m0_hlock;   lk[1] = bus.m1_hlock;
    rq[0] = bus.m0_hbusreq; rq[1] = bus.m1_hbusreq;
    ad[0] = bus.m0_haddr;   ad[1] = bus.m1_haddr;
    wd[0] = bus.m0_hwdata;  wd[1] = bus.m1_hwdata;
    ct[0] = {bus.m0_hwrite, bus.m0_hsize, bus.m0_hburst, bus.m0_hprot};
    ct[1] = {bus.m1_hwrite, bus.m1_hsize, bus.m1_hburst, bus.m1_hprot};
    o = m_owner;
    n = 1 - o;

    check("m0_hgrant", 32'(bus.m0_hgrant), 32'(m_grant == 0));
    check("m1_hgrant", 32'(bus.m1_hgrant), 32'(m_grant == 1));
    check("hmaster",   32'(bus.hmaster),   32'(m_owner));
    check("haddr",     bus.sysahb_haddr,   ad[o]);
    check("ctrl",      32'({bus.sysahb_hwrite, bus.sysahb_hsize, bus.sysahb_hburst, bus.sysahb_hprot}), 32'(ct[o]));
    check("htrans",    32'(bus.sysahb_htrans),    sys_rst ? 32'd0 : 32'(tr[o]));
    check("hmastlock", 32'(bus.sysahb_hmastlock), sys_rst ? 32'd0 : 32'(lk[o]));
    check("hwdata",    bus.sysahb_hwdata,  wd[m_data_owner]);
    check("resp_path", {bus.mst_hrdata[29:0], bus.mst_hready, bus.mst_hresp},
                       {bus.sysahb_hrdata[29:0], bus.sysahb_hready, bus.sysahb_hresp});

    if (sys_rst) begin
      model_reset();
    end else if (bus.sysahb_hready) begin
      nxt = m_grant;
      if (tr[o] != 2'd3 && !lk[o]) begin
        if (rq[0] && rq[1])  nxt = (m_beats >= TB_QUANTUM) ? n : o;
        else if (rq[0])      nxt = 0;
        else if (rq[1])      nxt = 1;
        else                 nxt = int'(TB_PARK);
      end
      if (m_grant != m_owner) m_beats = 0;
      else if (tr[o] >= 2'd2) m_beats = (m_beats >= 255) ? 255 : m_beats + 1;
      m_data_owner = m_owner;
      m_owner      = m_grant;
      m_grant      = nxt;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_hbusreq = 1'b0; bus.m0_hlock = 1'b0; bus.m0_haddr = 32'h0; bus.m0_htrans = 2'd0;
    bus.m0_hwrite = 1'b0; bus.m0_hsize = 3'd2; bus.m0_hburst = 3'd0; bus.m0_hprot = 4'h3; bus.m0_hwdata = 32'h0;
    bus.m1_hbusreq = 1'b0; bus.m1_hlock = 1'b0; bus.m1_haddr = 32'h0; bus.m1_htrans = 2'd0;
    bus.m1_hwrite = 1'b0; bus.m1_hsize = 3'd2; bus.m1_hburst = 3'd0; bus.m1_hprot = 4'h3; bus.m1_hwdata = 32'h0;
    bus.sysahb_hready = 1'b1; bus.sysahb_hresp = 1'b0; bus.sysahb_hrdata = 32'h0;
  endtask

  function automatic logic [1:0] pick_trans(input int seq_pct);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < seq_pct)           return 2'd3;
    else if (r < seq_pct + 10) return 2'd0;
    else if (r < seq_pct + 15) return 2'd1;
    else                       return 2'd2;
  endfunction

  function automatic logic next_lock(input int i, input int lock_pct);
    if (lock_run[i] > 0) begin
      lock_run[i]--;
      return 1'b1;
    end
    if (int'($urandom_range(0, 99)) < lock_pct) begin
      lock_run[i] = int'($urandom_range(1, 11));
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic random_inputs(input phase_t p);
    bus.m0_hbusreq = int'($urandom_range(0, 99)) < p.req0;
    bus.m1_hbusreq = int'($urandom_range(0, 99)) < p.req1;
    bus.m0_htrans  = pick_trans(p.seq);
    bus.m1_htrans  = pick_trans(p.seq);
    bus.m0_hlock   = next_lock(0, p.lock);
    bus.m1_hlock   = next_lock(1, p.lock);
    bus.m0_haddr   = $urandom;  bus.m1_haddr  = $urandom;
    bus.m0_hwdata  = $urandom;  bus.m1_hwdata = $urandom;
    {bus.m0_hwrite, bus.m0_hsize, bus.m0_hburst, bus.m0_hprot} = 11'($urandom);
    {bus.m1_hwrite, bus.m1_hsize, bus.m1_hburst, bus.m1_hprot} = 11'($urandom);
    bus.sysahb_hready = int'($urandom_range(0, 99)) < p.ready;
    bus.sysahb_hresp  = int'($urandom_range(0, 99)) < 5;
    bus.sysahb_hrdata = $urandom;
    sys_rst = int'($urandom_range(0, 999)) < p.rst;
  endtask

  phase_t phases [5];

  initial begin
    phases = '{
      '{req0: 100, req1: 100, seq: 0,  lock: 0,  ready: 100, rst: 0},
      '{req0: 90,  req1: 30,  seq: 45, lock: 0,  ready: 85,  rst: 0},
      '{req0: 70,  req1: 70,  seq: 10, lock: 15, ready: 75,  rst: 0},
      '{req0: 50,  req1: 80,  seq: 20, lock: 5,  ready: 40,  rst: 5},
      '{req0: 20,  req1: 20,  seq: 15, lock: 5,  ready: 70,  rst: 10}
    };
    lock_run[0] = 0;
    lock_run[1] = 0;
    idle_inputs();
    sys_rst = 1'b1;
    bus.sysahb_hready = 1'b0;
    @(posedge sys_clk);
    #1;
    model_reset();

    // Reset state with no requests: grant parks on master 0 and the bus is idle.
    check("rst_m0_hgrant", 32'(bus.m0_hgrant), 32'd1);
    check("rst_m1_hgrant", 32'(bus.m1_hgrant), 32'd0);
    check("rst_hmaster",   32'(bus.hmaster),   32'd0);
    check("rst_htrans",    32'(bus.sysahb_htrans), 32'd0);
    bus.sysahb_hready = 1'b1;
    step();

    // Master 0 single write: address phase, then its data phase.
    sys_rst = 1'b0;
    bus.m0_hbusreq = 1'b1; bus.m0_htrans = 2'd2; bus.m0_hwrite = 1'b1; bus.m0_haddr = 32'h2000_0010;
    #1;
    check("wr_haddr", bus.sysahb_haddr, 32'h2000_0010);
    step();
    bus.m0_hbusreq = 1'b0; bus.m0_htrans = 2'd0; bus.m0_hwdata = 32'hA5A5_A5A5;
    bus.m1_hbusreq = 1'b1;
    #1;
    check("wr_hwdata", bus.sysahb_hwdata, 32'hA5A5_A5A5);
    step();

    // Master 1 takes over: hgrant one cycle, then address ownership the next.
    check("m1_grant_c1",   32'(bus.m1_hgrant), 32'd1);
    check("m1_hmaster_c1", 32'(bus.hmaster),   32'd0);
    step();
    bus.m1_htrans = 2'd2; bus.m1_haddr = 32'h4000_0000;
    #1;
    check("m1_hmaster_c2", 32'(bus.hmaster),      32'd1);
    check("m1_haddr_c2",   bus.sysahb_haddr,      32'h4000_0000);
    step();

    foreach (phases[k]) begin
      for (int c = 0; c < 600; c++) begin
        random_inputs(phases[k]);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
